alu_arbiter: RTL
================

# alu_arbiter

Shares the single 32-bit ALU (adder, logic, SLT, shifter and its result/flag multiplexer) between two independent requesters, e.g. the execute stage and the debug/monitor port. It arbitrates round-robin, latches the winning operation and operands, drives the ALU control and operand buses for a fixed settle window, then captures the result and flags into a response register held under a valid/ready handshake.

## Interface
- ALU_LAT, 1, ALU settle cycles between issue and capture; legal range 1..15
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester i has an operation pending
- req0_ready / req1_ready  out  1  arbiter accepts requester i this cycle
- req0_op / req1_op  in  3  ALU control code (000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SLT, 111 SHIFT)
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- alu_ctrl  out  3  control to ALU result/flag mux
- alu_a, alu_b  out  32  operands to ALU
- alu_result  in  32  ALU bus output
- alu_c, alu_v  in  1  ALU carry / overflow flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_data  out  32  captured result
- rsp_flags  out  4  {N, Z, C, V}

## Operation
- States: IDLE, ISSUE, RESP. Reset: state IDLE, all outputs 0, last_grant = 1 (req0 wins first tie).
- IDLE: grant computed combinationally. Only one valid -> that one. Both valid -> the one not equal to last_grant. req_ready of granted requester = 1 while in IDLE, other = 0. On valid && ready: latch op, a, b, id; last_grant <= id; counter <= ALU_LAT-1; go ISSUE.
- ISSUE: alu_ctrl/alu_a/alu_b = latched values (all zero in every other state). Counter decrements each cycle; at counter 0 capture rsp_data = alu_result, C = alu_c, V = alu_v, Z = (alu_result == 0), N = alu_result[31]; go RESP.
- RESP: rsp_valid = 1, rsp_id/data/flags stable. On rsp_ready go IDLE; rsp_valid drops next cycle. Stalls indefinitely while rsp_ready = 0; no request accepted during ISSUE or RESP.
- Op NOP (000) still runs the full sequence; result 0, Z = 1, C = V = 0.
- Flags passed as delivered by the ALU; the arbiter does not mask C/V per opcode.
- Requester may drop valid while not granted; no state is kept for it.
- Reset asserted in any state aborts the operation; no response is produced; outputs clear asynchronously.

## Timing
- Accept at edge N (valid && ready sampled); ISSUE covers cycles N+1..N+ALU_LAT; rsp_valid high from cycle N+ALU_LAT+1.
- With rsp_ready held 1: RESP lasts one cycle; next accept earliest in cycle N+ALU_LAT+2; peak throughput one op per ALU_LAT+2 cycles.
- req_ready is combinational from req_valid, state, last_grant; no combinational path from alu_* inputs to any output.
- All rsp_* outputs registered.

## Configuration
- ALU_ARB_FIXED_PRIORITY_EN: defined -> req0 always wins when both valid; last_grant ignored (still updated). Undefined -> round-robin as above.

## Test plan
- Reset, req0 ADD a=0x7FFFFFFF b=1, ALU_LAT=1, rsp_ready=1 -> accept cycle 0, rsp_valid cycle 2, rsp_id=0, data=0x80000000, flags N=1 Z=0 C=0 V=1.
- Both valid every cycle, 4 ops, round-robin build -> rsp_id sequence 0,1,0,1; fixed-priority build -> 0,0,0,0.
- req1 SUB a=5 b=5, ALU_LAT=3 -> alu_ctrl=010 for exactly 3 cycles, rsp_valid at cycle 4, data=0, Z=1, C=1.
- rsp_ready low 10 cycles after response with req0 valid -> rsp_* stable, req0_ready=0 throughout, accept one cycle after rsp_ready rises.
- rst_n pulsed low during ISSUE -> all outputs 0 immediately, no rsp_valid afterwards, next tie granted to req0.
- req0 SLT a=0xFFFFFFFF b=1 -> data=0x00000001, N=0 Z=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters: accept, drive ALU for ALU_LAT cycles, capture into a held response.
// Optional build macro ALU_ARB_FIXED_PRIORITY_EN: req0 always wins a tie (last_grant still tracked).
module alu_arbiter #(
    parameter int ALU_LAT = 1  // settle cycles between issue and capture, legal 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t      state, state_next;
    logic        last_grant;
    logic [3:0]  count;
    logic [2:0]  op_lat;
    logic [31:0] a_lat, b_lat;
    logic        id_lat;
    logic        grant_any, grant_id, accept;

    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = ~req0_valid;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant;
`endif
        end
        req0_ready = (state == IDLE) && grant_any && !grant_id;
        req1_ready = (state == IDLE) && grant_any && grant_id;
        accept     = req0_ready | req1_ready;

        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (count == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ALU buses are driven only while an operation is in flight; zero otherwise.
    always_comb begin
        alu_ctrl = 3'b000;
        alu_a    = 32'h0;
        alu_b    = 32'h0;
        if (state == ISSUE) begin
            alu_ctrl = op_lat;
            alu_a    = a_lat;
            alu_b    = b_lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            count      <= 4'd0;
            op_lat     <= 3'b000;
            a_lat      <= 32'h0;
            b_lat      <= 32'h0;
            id_lat     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 32'h0;
            rsp_flags  <= 4'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_lat     <= grant_id ? req1_op : req0_op;
                        a_lat      <= grant_id ? req1_a  : req0_a;
                        b_lat      <= grant_id ? req1_b  : req0_b;
                        id_lat     <= grant_id;
                        last_grant <= grant_id;
                        count      <= CNT_INIT;
                    end
                end
                ISSUE: begin
                    if (count == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_lat;
                        rsp_data  <= alu_result;
                        rsp_flags <= {alu_result[31], (alu_result == 32'h0), alu_c, alu_v};
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
